// File: rtl/ysyx_22041207_div.sv
// ysyx_22041207_div -- iterative radix-2 restoring divider for the EX stage.
// Covers RV64M DIV/DIVU/REM/REMU and the word forms DIVW/DIVUW/REMW/REMUW.
//
// Ports:
//   clk         clock, all state on posedge
//   rst         asynchronous active-high reset
//   valid       start request; accepted when valid && ready && !flush
//   flush       abandons the current operation, returns to IDLE
//   a, b        dividend / divisor (XLEN bits)
//   div_signed  1: signed (DIV/REM), 0: unsigned
//   div_rem     1: return remainder, 0: quotient
//   div_word    1: 32-bit op on a[31:0]/b[31:0], result sign-extended
//   ready       high only in IDLE
//   out_valid   one-cycle pulse when res is valid
//   res         result, held until the next accept
//
// Optional build macro YSYX_22041207_DIV_FASTPATH_EN: divide-by-zero, signed
// overflow and |a|<|b| finish without iterating (out_valid the cycle after
// accept). Results are identical with or without it.
module ysyx_22041207_div #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic            flush,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            div_signed,
  input  logic            div_rem,
  input  logic            div_word,
  output logic            ready,
  output logic            out_valid,
  output logic [XLEN-1:0] res
);

  localparam int H  = XLEN / 2;
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

  state_t          state;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] absb;
  logic [CW-1:0]   cnt;
  logic            qneg;
  logic            rneg;
  logic            sel_rem;
  logic            word;
`ifdef YSYX_22041207_DIV_FASTPATH_EN
  logic            fast_done;
`endif

  assign ready = (state == IDLE);

  // Sign application, quotient/remainder select and word sign-extension.
  function automatic logic [XLEN-1:0] fixup(input logic [XLEN-1:0] q,
                                            input logic [XLEN-1:0] r,
                                            input logic qn, input logic rn,
                                            input logic sr, input logic w);
    logic [XLEN-1:0] v;
    v = sr ? (rn ? -r : r) : (qn ? -q : q);
    if (w) v = {{H{v[H-1]}}, v[H-1:0]};
    return v;
  endfunction

  // Operand preparation for the accept edge.
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, quo_init;
  logic            sa, sb, acc_qneg;

  always_comb begin
    a_ext = a;
    b_ext = b;
    if (div_word) begin
      a_ext = {{H{div_signed & a[H-1]}}, a[H-1:0]};
      b_ext = {{H{div_signed & b[H-1]}}, b[H-1:0]};
    end
    sa       = div_signed & a_ext[XLEN-1];
    sb       = div_signed & b_ext[XLEN-1];
    abs_a    = sa ? -a_ext : a_ext;
    abs_b    = sb ? -b_ext : b_ext;
    acc_qneg = div_signed & (sa ^ sb) & (abs_b != '0);
    // Word dividends sit in the upper half so that H shifts bring every
    // dividend bit through the remainder; the quotient lands in quo[H-1:0].
    quo_init = div_word ? {abs_a[H-1:0], {H{1'b0}}} : abs_a;
  end

`ifdef YSYX_22041207_DIV_FASTPATH_EN
  logic            fast_hit;
  logic [XLEN-1:0] fast_quo, fast_rem;
  logic [XLEN-1:0] min_mag;

  always_comb begin
    min_mag  = div_word ? (XLEN'(1) << (H - 1)) : (XLEN'(1) << (XLEN - 1));
    fast_hit = 1'b0;
    fast_quo = '0;
    fast_rem = abs_a;
    if (abs_b == '0) begin
      fast_hit = 1'b1;
      fast_quo = '1;
    end else if (div_signed && sa && sb && abs_b == XLEN'(1) && abs_a == min_mag) begin
      fast_hit = 1'b1;
      fast_quo = abs_a;
      fast_rem = '0;
    end else if (abs_a < abs_b) begin
      fast_hit = 1'b1;
    end
  end
`endif

  // One restoring step. The shifted remainder needs XLEN+1 bits for
  // unsigned divisors above 2^(XLEN-1).
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_next;

  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    diff     = shifted - {1'b0, absb};
    ge       = (shifted >= {1'b0, absb});
    rem_next = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      res       <= '0;
      rem       <= '0;
      quo       <= '0;
      absb      <= '0;
      cnt       <= '0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
      sel_rem   <= 1'b0;
      word      <= 1'b0;
`ifdef YSYX_22041207_DIV_FASTPATH_EN
      fast_done <= 1'b0;
`endif
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
`ifdef YSYX_22041207_DIV_FASTPATH_EN
      fast_done <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (valid) begin
            absb    <= abs_b;
            qneg    <= acc_qneg;
            rneg    <= sa;
            sel_rem <= div_rem;
            word    <= div_word;
            cnt     <= div_word ? CW'(H) : CW'(XLEN);
`ifdef YSYX_22041207_DIV_FASTPATH_EN
            if (fast_hit) begin
              // Result is registered on the accept edge; FIX only retires.
              quo       <= fast_quo;
              rem       <= fast_rem;
              res       <= fixup(fast_quo, fast_rem, acc_qneg, sa, div_rem, div_word);
              out_valid <= 1'b1;
              fast_done <= 1'b1;
              state     <= FIX;
            end else begin
              quo   <= quo_init;
              rem   <= '0;
              state <= BUSY;
            end
`else
            quo   <= quo_init;
            rem   <= '0;
            state <= BUSY;
`endif
          end
        end
        BUSY: begin
          rem <= rem_next;
          quo <= {quo[XLEN-2:0], ge};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
`ifdef YSYX_22041207_DIV_FASTPATH_EN
          if (fast_done) begin
            out_valid <= 1'b0;
            fast_done <= 1'b0;
          end else begin
            res       <= fixup(quo, rem, qneg, rneg, sel_rem, word);
            out_valid <= 1'b1;
          end
`else
          res       <= fixup(quo, rem, qneg, rneg, sel_rem, word);
          out_valid <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_div.sv
module tb_ysyx_22041207_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        div_signed = 1'b0;
  logic        div_rem = 1'b0;
  logic        div_word = 1'b0;
  logic        ready;
  logic        out_valid;
  logic [63:0] res;

  ysyx_22041207_div #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .valid(valid), .flush(flush), .a(a), .b(b),
    .div_signed(div_signed), .div_rem(div_rem), .div_word(div_word),
    .ready(ready), .out_valid(out_valid), .res(res)
  );

  always #5 clk = ~clk;

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

`ifdef YSYX_22041207_DIV_FASTPATH_EN
  localparam bit FASTPATH = 1'b1;
`else
  localparam bit FASTPATH = 1'b0;
`endif

  typedef struct {
    logic [63:0] res;
    int unsigned due;
    int unsigned id;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned next_id = 0;
  logic [63:0] last_res = '0;

  // RISC-V M-extension semantics with plain arithmetic.
  function automatic logic [63:0] model(input logic [63:0] ia, input logic [63:0] ib,
                                        input logic s, input logic rm, input logic w);
    logic [31:0] aw, bw, r32;
    int          sa32, sb32;
    longint      sa64, sb64;
    logic [63:0] r;
    if (w) begin
      aw = ia[31:0];
      bw = ib[31:0];
      if (bw == 32'd0) r32 = rm ? aw : 32'hFFFF_FFFF;
      else if (s && aw == 32'h8000_0000 && bw == 32'hFFFF_FFFF) r32 = rm ? 32'd0 : aw;
      else if (s) begin
        sa32 = aw;
        sb32 = bw;
        r32  = rm ? sa32 % sb32 : sa32 / sb32;
      end else r32 = rm ? aw % bw : aw / bw;
      r = {{32{r32[31]}}, r32};
    end else begin
      if (ib == 64'd0) r = rm ? ia : 64'hFFFF_FFFF_FFFF_FFFF;
      else if (s && ia == 64'h8000_0000_0000_0000 && ib == 64'hFFFF_FFFF_FFFF_FFFF) r = rm ? 64'd0 : ia;
      else if (s) begin
        sa64 = ia;
        sb64 = ib;
        r    = rm ? sa64 % sb64 : sa64 / sb64;
      end else r = rm ? ia % ib : ia / ib;
    end
    return r;
  endfunction

  // Negedge (relative to issue negedge) at which out_valid is expected.
  function automatic int unsigned due_off(input logic [63:0] ia, input logic [63:0] ib,
                                          input logic s, input logic w);
    logic [63:0] xa, xb, ma, mb, minv;
    bit          ovf;
    if (w) begin
      xa   = s ? {{32{ia[31]}}, ia[31:0]} : {32'd0, ia[31:0]};
      xb   = s ? {{32{ib[31]}}, ib[31:0]} : {32'd0, ib[31:0]};
      minv = 64'h0000_0000_8000_0000;
    end else begin
      xa   = ia;
      xb   = ib;
      minv = 64'h8000_0000_0000_0000;
    end
    ma  = (s && xa[63]) ? (~xa + 64'd1) : xa;
    mb  = (s && xb[63]) ? (~xb + 64'd1) : xb;
    ovf = s && ma == minv && xa[63] && xb == 64'hFFFF_FFFF_FFFF_FFFF;
    if (FASTPATH && (mb == 64'd0 || ovf || ma < mb)) return 1;
    return w ? 34 : 66;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic issue(input logic [63:0] ia, input logic [63:0] ib, input logic s,
                       input logic rm, input logic w, input bit push,
                       output int unsigned icyc);
    int unsigned n;
    exp_t        e;
    n = 0;
    @(negedge clk);
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout got=0 want=1");
    end
    a = ia; b = ib; div_signed = s; div_rem = rm; div_word = w;
    valid = 1'b1;
    icyc  = cycle;
    if (push) begin
      e.res = model(ia, ib, s, rm, w);
      e.due = cycle + due_off(ia, ib, s, w);
      e.id  = next_id;
      next_id++;
      sb_q.push_back(e);
    end
    @(negedge clk);
    valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
  endtask

  // Monitor: every out_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_out_valid got=1 want=0 res=%h", res);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        if (res !== e.res) begin
          failures++;
          $display("FAIL res_op%0d got=%h want=%h", e.id, res, e.res);
        end
        checks++;
        if (cycle !== e.due) begin
          failures++;
          $display("FAIL latency_op%0d got=%0d want=%0d", e.id, cycle, e.due);
        end
        last_res = e.res;
      end
    end
  end

  function automatic logic [63:0] pick_operand(input int unsigned kind);
    logic [63:0] v;
    v = {$urandom, $urandom};
    case (kind)
      0: v = 64'($urandom_range(0, 1000));
      1: v = 64'd0;
      2: v = 64'hFFFF_FFFF_FFFF_FFFF;
      3: v = 64'h8000_0000_0000_0000;
      4: v = {32'hFFFF_FFFF, 32'h8000_0000};
      5: v = {$urandom, 32'($urandom_range(0, 1) ? 32'h8000_0000 : 32'h0000_0005)};
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    int unsigned c;
    int unsigned n;

    repeat (2) @(negedge clk);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_res", res, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {63'd0, ready}, 64'd1);

    // Directed cases.
    issue(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 1'b1, c);
    issue(64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 1'b1, c);
    issue(-64'sd100, 64'd7, 1'b1, 1'b0, 1'b0, 1'b1, c);
    issue(-64'sd100, 64'd7, 1'b1, 1'b1, 1'b0, 1'b1, c);
    issue(64'h1234, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, c);
    issue(64'h1234, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, c);
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, c);
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1, c);
    issue(64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, c);
    issue(64'h0000_0000_8000_0000, 64'd2, 1'b0, 1'b0, 1'b1, 1'b1, c);
    issue(64'h0000_0000_8000_0000, 64'd0, 1'b1, 1'b1, 1'b1, 1'b1, c);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0, 1'b1, 1'b0, 1'b1, c);

    // Flush while BUSY: no pulse, ready next cycle, res unchanged.
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    issue(64'h0123_4567_89AB_CDEF, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0, c);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    valid = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    valid = 1'b0;
    check("ready_after_flush", {63'd0, ready}, 64'd1);
    check("res_held_after_flush", res, last_res);

    // valid together with flush in IDLE must not start an op.
    a = 64'd50; b = 64'd5;
    valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    flush = 1'b0;
    check("valid_flush_not_accepted", {63'd0, ready}, 64'd1);

    // Flush in FIX suppresses the pulse.
    issue(64'h0FED_CBA9_8765_4321, 64'd3, 1'b0, 1'b1, 1'b0, 1'b0, c);
    while (cycle < c + 65) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("ready_after_fix_flush", {63'd0, ready}, 64'd1);
    repeat (70) @(negedge clk);
    check("res_held_after_fix_flush", res, last_res);

    // Reset mid-operation.
    issue(64'h7777_0000_1111_2222, 64'd9, 1'b1, 1'b0, 1'b0, 1'b0, c);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_res", res, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    @(negedge clk);
    check("ready_after_mid_rst", {63'd0, ready}, 64'd1);

    // Randomized operations.
    for (int i = 0; i < 48; i++) begin
      logic [63:0] ra, rb;
      ra = pick_operand($urandom_range(0, 9));
      rb = pick_operand($urandom_range(0, 9));
      issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b1, c);
    end

    n = 0;
    while (sb_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d want=0 pending", sb_q.size());
    end
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
